// File: rtl/piezo_pkg.sv
// Shared types and note table for the piezo tone player.
package piezo_pkg;

    localparam int unsigned NUM_NOTES = 5;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned SHIFT_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Half-period in clocks for note idx (C4..G4), scaled down by shift, never below 1.
    function automatic logic [CNT_W-1:0] half_period(input logic [IDX_W-1:0] idx,
                                                     input logic [SHIFT_W-1:0] shift);
        logic [CNT_W-1:0] base;
        logic [CNT_W-1:0] hp;
        case (idx)
            3'd0:    base = 32'd191110;
            3'd1:    base = 32'd170265;
            3'd2:    base = 32'd151685;
            3'd3:    base = 32'd143172;
            default: base = 32'd127551;
        endcase
        hp = base >> shift;
        return (hp == '0) ? CNT_W'(1) : hp;
    endfunction

endpackage

// File: rtl/piezo_square_gen.sv
// Half-period counter and phase toggle; exposes the next phase so the caller can register its pin.
module piezo_square_gen
    import piezo_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             en,
    input  logic [CNT_W-1:0] half_period,
    output logic             phase_nxt_c
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             phase;

    // start begins a note on the high half; neither start nor en parks the generator low
    always_comb begin
        cnt_nxt     = '0;
        phase_nxt_c = 1'b0;
        if (start) begin
            phase_nxt_c = 1'b1;
        end else if (en) begin
            if (cnt == half_period - CNT_W'(1)) begin
                phase_nxt_c = ~phase;
            end else begin
                cnt_nxt     = cnt + CNT_W'(1);
                phase_nxt_c = phase;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            phase <= phase_nxt_c;
        end
    end

endmodule

// File: rtl/piezo_tone_player.sv
// Plays one fixed-length square-wave note per button press, followed by a silent gap.
module piezo_tone_player
    import piezo_pkg::*;
#(
    parameter logic [CNT_W-1:0]   TONE_CYCLES = 32'd20_000_000,
    parameter logic [CNT_W-1:0]   GAP_CYCLES  = 32'd5_000_000,
    parameter logic [SHIFT_W-1:0] HP_SHIFT    = 5'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_NOTES-1:0] btn_level,
    input  logic                 mute,
    output logic                 buzzer,
    output logic                 busy,
    output logic [IDX_W-1:0]     note_idx,
    output logic                 note_done
);

    localparam logic [CNT_W-1:0] GAP_LEN = (GAP_CYCLES == '0) ? CNT_W'(1) : GAP_CYCLES;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     dur_cnt, dur_nxt;
    logic [NUM_NOTES-1:0] btn_q;
    logic                 armed;
    logic                 pend_v, pend_v_nxt;
    logic [IDX_W-1:0]     pend_idx, pend_idx_nxt;
    logic [IDX_W-1:0]     note_idx_nxt;
    logic                 note_done_nxt;
    logic                 buzzer_nxt;
    logic [NUM_NOTES-1:0] edge_c;
    logic [IDX_W-1:0]     win_idx_c;
    logic                 start_c;
    logic                 en_c;
    logic                 phase_nxt_c;
    logic [CNT_W-1:0]     hp_c;

    // Levels already high when reset releases are not treated as presses
    assign edge_c = armed ? (btn_level & ~btn_q) : '0;
    assign hp_c   = half_period(note_idx, HP_SHIFT);

    always_comb begin
        win_idx_c = '0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (edge_c[i]) win_idx_c = IDX_W'(i);
        end
    end

    always_comb begin
        state_nxt     = state;
        dur_nxt       = dur_cnt;
        pend_v_nxt    = pend_v;
        pend_idx_nxt  = pend_idx;
        note_idx_nxt  = note_idx;
        note_done_nxt = 1'b0;
        start_c       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|edge_c) begin
                    state_nxt    = ST_PLAY;
                    note_idx_nxt = win_idx_c;
                    dur_nxt      = '0;
                    start_c      = 1'b1;
                end
            end
            ST_PLAY: begin
                if (|edge_c) begin
                    pend_v_nxt   = 1'b1;
                    pend_idx_nxt = win_idx_c;
                end
                if (dur_cnt == TONE_CYCLES - CNT_W'(1)) begin
                    state_nxt     = ST_GAP;
                    dur_nxt       = '0;
                    note_done_nxt = 1'b1;
                end else begin
                    dur_nxt = dur_cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (|edge_c) begin
                    pend_v_nxt   = 1'b1;
                    pend_idx_nxt = win_idx_c;
                end
                if (dur_cnt == GAP_LEN - CNT_W'(1)) begin
                    dur_nxt = '0;
                    if (pend_v_nxt) begin
                        state_nxt    = ST_PLAY;
                        note_idx_nxt = pend_idx_nxt;
                        pend_v_nxt   = 1'b0;
                        start_c      = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    dur_nxt = dur_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                dur_nxt   = '0;
            end
        endcase
    end

    assign en_c       = (state == ST_PLAY) && (state_nxt == ST_PLAY);
    assign buzzer_nxt = (state_nxt == ST_PLAY) && phase_nxt_c && !mute;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            dur_cnt   <= '0;
            btn_q     <= '0;
            armed     <= 1'b0;
            pend_v    <= 1'b0;
            pend_idx  <= '0;
            note_idx  <= '0;
            note_done <= 1'b0;
            buzzer    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            dur_cnt   <= dur_nxt;
            btn_q     <= btn_level;
            armed     <= 1'b1;
            pend_v    <= pend_v_nxt;
            pend_idx  <= pend_idx_nxt;
            note_idx  <= note_idx_nxt;
            note_done <= note_done_nxt;
            buzzer    <= buzzer_nxt;
            busy      <= (state_nxt != ST_IDLE);
        end
    end

    piezo_square_gen u_square_gen (
        .clk         (clk),
        .reset       (reset),
        .start       (start_c),
        .en          (en_c),
        .half_period (hp_c),
        .phase_nxt_c (phase_nxt_c)
    );

endmodule

// File: tb/tb_piezo_tone_player.sv
// Bench for piezo_tone_player: directed scenarios plus random presses against a note-schedule model.
module tb_piezo_tone_player;

    localparam int TONE  = 40;
    localparam int GAP   = 8;
    localparam int SHIFT = 14;

    logic       clk;
    logic       reset;
    logic [4:0] btn_level;
    logic       mute;
    logic       buzzer;
    logic       busy;
    logic [2:0] note_idx;
    logic       note_done;

    int n_checks = 0;
    int n_errors = 0;

    piezo_tone_player #(
        .TONE_CYCLES (32'(TONE)),
        .GAP_CYCLES  (32'(GAP)),
        .HP_SHIFT    (5'(SHIFT))
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_level (btn_level),
        .mute      (mute),
        .buzzer    (buzzer),
        .busy      (busy),
        .note_idx  (note_idx),
        .note_done (note_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 playing, 2 gap; k = clocks elapsed in the mode
    int         note_table [5] = '{191110, 170265, 151685, 143172, 127551};
    int         m_mode, m_k, m_note, m_done;
    bit         m_first;
    logic [4:0] m_prev;
    int         pend_q [$];

    function automatic int hp_of(input int idx);
        int h;
        h = note_table[idx] >> SHIFT;
        return (h < 1) ? 1 : h;
    endfunction

    task automatic model_clear();
        m_mode = 0; m_k = 0; m_note = 0; m_done = 0;
        m_first = 1'b1; m_prev = '0;
        pend_q.delete();
    endtask

    task automatic model_step();
        logic [4:0] edges;
        int         win;
        m_done = 0;
        if (!reset) begin
            model_clear();
            return;
        end
        edges   = m_first ? 5'd0 : (btn_level & ~m_prev);
        m_prev  = btn_level;
        m_first = 1'b0;
        win = -1;
        for (int i = 4; i >= 0; i--) if (edges[i]) win = i;
        case (m_mode)
            0: if (win >= 0) begin
                m_mode = 1; m_note = win; m_k = 0;
            end
            1: begin
                if (win >= 0) begin pend_q.delete(); pend_q.push_back(win); end
                m_k++;
                if (m_k == TONE) begin m_mode = 2; m_k = 0; m_done = 1; end
            end
            default: begin
                if (win >= 0) begin pend_q.delete(); pend_q.push_back(win); end
                m_k++;
                if (m_k == GAP) begin
                    m_k = 0;
                    if (pend_q.size() > 0) begin
                        m_mode = 1; m_note = pend_q.pop_front();
                    end else begin
                        m_mode = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic exp_buz;
        exp_buz = (m_mode == 1) && (((m_k / hp_of(m_note)) % 2) == 0) && !mute;
        check("buzzer",    32'(buzzer),    32'(exp_buz));
        check("busy",      32'(busy),      32'(m_mode != 0));
        check("note_idx",  32'(note_idx),  32'(m_note));
        check("note_done", 32'(note_done), 32'(m_done));
    endtask

    // Advance n clocks; model steps and outputs are compared at each falling edge
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            model_step();
            check_all();
        end
    endtask

    int hi_cnt;

    initial begin
        reset = 1'b0; btn_level = 5'h1F; mute = 1'b0;
        model_clear();
        #1;
        check("rst_buzzer", 32'(buzzer), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_idx",    32'(note_idx), 32'd0);
        run(3);
        reset = 1'b1;
        run(5);
        check("no_edge_on_release", 32'(busy), 32'd0);
        btn_level = 5'h00;
        run(3);

        // Single C4 note: count the high clocks of the first half-cycle
        btn_level = 5'b00001;
        run(1);
        hi_cnt = 0;
        while (buzzer === 1'b1 && hi_cnt < 50) begin
            hi_cnt++;
            run(1);
        end
        check("c4_high_len", 32'(hi_cnt), 32'd11);
        run(60);
        btn_level = 5'b00000;
        run(3);

        // Simultaneous bits 2 and 4: lowest wins, one note only
        btn_level = 5'b10100;
        run(1);
        check("prio_idx", 32'(note_idx), 32'd2);
        run(60);
        check("prio_single", 32'(busy), 32'd0);
        btn_level = 5'b00000;
        run(2);

        // Note on idx1, then btn3 and btn4 pressed during it: newest pending wins
        btn_level = 5'b00010; run(10);
        btn_level = 5'b01010; run(5);
        btn_level = 5'b11010; run(5);
        btn_level = 5'b00000; run(40);
        check("newest_idx", 32'(note_idx), 32'd4);
        run(60);

        // Muted note keeps timing
        mute = 1'b1;
        btn_level = 5'b00100; run(55);
        mute = 1'b0;
        btn_level = 5'b00000; run(3);

        // Async reset mid-note with a pending press
        btn_level = 5'b00010; run(20);
        btn_level = 5'b01010; run(3);
        #2 reset = 1'b0;
        #1;
        check("async_buzzer", 32'(buzzer), 32'd0);
        check("async_busy",   32'(busy),   32'd0);
        run(2);
        reset = 1'b1;
        run(60);
        check("no_pending_after_rst", 32'(busy), 32'd0);
        btn_level = 5'b00000;
        run(2);

        // Random presses, mute toggles and occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0)
                btn_level[$urandom_range(0, 4)] = ~btn_level[$urandom_range(0, 4)];
            if ($urandom_range(0, 39) == 0) btn_level = 5'(($urandom()));
            if ($urandom_range(0, 59) == 0) mute = ~mute;
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 699) == 0) reset = 1'b0;
            run(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
